// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port round-robin arbiter and sequencer that sits in front of the
// single-ported data memory. Port 0 is the CPU load/store unit, port 1 is the
// loader/debug master. Each accepted command takes exactly one memory cycle,
// and its result comes back as a registered, one-cycle response pulse that
// carries a misalignment flag.
//
// Ports:
//   clock, reset_n          system clock (rising edge), async active-low reset
//   req0/req1               requester has a command; held until its grant
//   we0/we1                 1 = write, 0 = read
//   addr0/addr1             byte address of the access
//   wdata0/wdata1           write data
//   gnt0/gnt1               command is accepted at the next rising edge
//   rvalid0/rvalid1         one-cycle response pulse
//   rdata0/rdata1           read data, held until the next response
//   err0/err1               misaligned-access flag, held like rdata
//   memwrite/memread        memory strobes (never both high)
//   address/writedata       memory address and write data
//   readdata                memory read data (combinational from address)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  memwrite,
    output logic                  memread,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;

    // Round-robin pointer: the port that wins when both are requesting.
    logic                  r_ptr;

    // Command latched at the grant edge; the requester is free afterwards.
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_err0;
    logic                  r_err1;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_aligned;
    logic [DATA_WIDTH-1:0] w_readResult;

    assign w_aligned = (r_addr[1:0] == 2'b00);

    // Writes and misaligned accesses return zero rather than whatever the
    // memory happens to present on its read bus.
    assign w_readResult = (!r_we && w_aligned) ? readdata : '0;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state, grant and strobe logic. Grants only exist in IDLE, and the
    // pointer only matters when both ports are requesting, so a lone
    // requester always wins. reset_n gates the grants so nothing is offered
    // while the block is held in reset.
    always_comb begin
        w_stateNext = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        memwrite    = 1'b0;
        memread     = 1'b0;
        case (r_state)
            IDLE: begin
                if (reset_n) begin
                    w_gnt0 = req0 && (!req1 || (r_ptr == 1'b0));
                    w_gnt1 = req1 && (!req0 || (r_ptr == 1'b1));
                end
                if (w_gnt0 || w_gnt1) begin
                    w_stateNext = ACCESS;
                end
            end
            ACCESS: begin
                memwrite    = r_we && w_aligned;
                memread     = !r_we && w_aligned;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Capture the granted command and hand priority to the other port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= 1'b0;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_gnt0) begin
            r_ptr   <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= we0;
            r_addr  <= addr0;
            r_wdata <= wdata0;
        end else if (w_gnt1) begin
            r_ptr   <= 1'b0;
            r_port  <= 1'b1;
            r_we    <= we1;
            r_addr  <= addr1;
            r_wdata <= wdata1;
        end
    end

    // Response registers. rvalid pulses for the cycle after ACCESS; data and
    // error flag are only updated for the port that owned the access so the
    // other port's last response stays visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= (r_state == ACCESS) && (r_port == 1'b0);
            r_rvalid1 <= (r_state == ACCESS) && (r_port == 1'b1);
            if (r_state == ACCESS) begin
                if (r_port == 1'b0) begin
                    r_rdata0 <= w_readResult;
                    r_err0   <= !w_aligned;
                end else begin
                    r_rdata1 <= w_readResult;
                    r_err1   <= !w_aligned;
                end
            end
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign address   = r_addr;
    assign writedata = r_wdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of data_memory.
- Port 0 is the CPU load/store unit; port 1 is the loader/debug master.
- Serialises their word accesses onto the single memory port (memwrite, memread, address, writedata, readdata).
- Returns a registered response with an alignment-error flag per access.

Parameters:
- ADDR_WIDTH, 32, width of the requester and memory address buses.
- DATA_WIDTH, 32, width of the write and read data buses.

Ports:
- clock  input  1  single system clock; rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0/req1  input  1  requester i has a valid command; held until gnt_i.
- we0/we1  input  1  1 = write, 0 = read; held with req_i.
- addr0/addr1  input  ADDR_WIDTH  byte address; held with req_i.
- wdata0/wdata1  input  DATA_WIDTH  write data; held with req_i.
- gnt0/gnt1  output  1  command accepted at the next rising edge (combinational).
- rvalid0/rvalid1  output  1  one-cycle response pulse for requester i.
- rdata0/rdata1  output  DATA_WIDTH  read data; valid while rvalid_i is high.
- err0/err1  output  1  misaligned access flag; valid while rvalid_i is high.
- memwrite  output  1  memory write strobe.
- memread  output  1  memory read strobe.
- address  output  ADDR_WIDTH  memory address.
- writedata  output  DATA_WIDTH  memory write data.
- readdata  input  DATA_WIDTH  memory read data; combinational from address while memread is high.

Behaviour:
- FSM states: IDLE and ACCESS. State, the latched command (port id, we, addr, wdata) and the priority pointer are registers.
- Grant rule (IDLE only):
  - gnt_i = req_i and state==IDLE and (req_other==0 or pointer==i).
  - At most one gnt per cycle.
  - No gnt is issued in ACCESS.
- IDLE + grant:
  - At the edge, latch the granted command, go to ACCESS, and set the pointer to the other port.
  - The requester may change or drop its signals after that edge.
- ACCESS (exactly one cycle):
  - address = latched addr; writedata = latched wdata.
  - memwrite = latched we and aligned; memread = not latched we and aligned.
  - aligned = (addr[1:0]==0).
  - At the edge: capture readdata into the response register (0 if write or misaligned), set err = not aligned, pulse rvalid for the latched port, return to IDLE.
- Response:
  - rvalid_i is high for exactly one cycle, the cycle after ACCESS.
  - rdata_i and err_i hold their value until the next response for that port.
- Timing:
  - Grant cycle C0, memory strobe C1, rvalid C2.
  - A new grant may occur in C2, so sustained throughput is one access per 2 cycles.
- Strobes and buses:
  - memwrite and memread are never both high.
  - Both are low in IDLE.
  - address and writedata are don't-care when the strobes are low; drive the latched values.
- Fairness:
  - With both ports requesting continuously, grants alternate 0,1,0,1.
  - A lone requester is granted every IDLE cycle regardless of the pointer.
- Reset (asynchronous, any time, including during ACCESS):
  - state=IDLE, pointer=port 0.
  - memwrite=memread=0; rvalid0/1=0; err0/1=0; rdata0/1=0; latched command=0.
  - An in-flight access is discarded with no response.
  - While reset_n is low, gnt0/1 are forced to 0.
- Simultaneous events: a req edge arriving during ACCESS waits for the next IDLE; an rvalid pulse and a new gnt in the same cycle are legal.

Test Plan:
- Port 0 writes 0xAAAA_BBBB to addr 0, then reads addr 0 -> memwrite high one cycle with address 0; read returns rvalid0 with rdata0=0xAAAA_BBBB, err0=0, two cycles after the gnt0 cycle.
- Both ports hold req after reset: port 0 reads addr 4, port 1 reads addr 8 (preloaded 0x1234_5678, 0xDEAD_BEEF) -> gnt0 first, then gnt1 two cycles later; rdata0=0x1234_5678, rdata1=0xDEAD_BEEF; grants alternate while both requests are held.
- Port 1 writes 0xDEAD_BEEF to addr 6 (misaligned) -> memwrite stays 0; rvalid1 with err1=1, rdata1=0; a later aligned read of addr 4 is unchanged.
- Port 1 alone issues 4 back-to-back reads -> gnt1 every 2 cycles; 4 rvalid1 pulses; port 0 outputs stay 0.
- reset_n driven low during ACCESS of a port 0 write to addr 8 -> memwrite drops immediately; no rvalid0; all outputs reset; after release the first grant goes to port 0 when both ports request.
- Write from port 0 and read of the same address from port 1 requested in the same cycle -> write serviced first; port 1 read returns the new data.
